accel_slv: RTL

- Receive end of the accelerometer serial link. Deserialises 8N1 UART bytes from RX_A and reassembles 16-bit acceleration samples sent high byte first, then low byte.
- Presents each completed sample with a one-cycle valid strobe.
- Resynchronises to packet boundaries using an inter-byte timeout, so a lost or corrupted byte never pairs a low byte with the wrong high byte.

---
 rtl/accel_slv.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/accel_slv.sv
// ---------------------------------------------------------------------------
// accel_slv : receive end of the accelerometer serial link.
//
// Deserialises 8N1 UART bytes arriving on RX_A and pairs them into 16-bit
// acceleration samples (high byte first, then low byte). An inter-byte
// timeout stops a lost or corrupted byte from pairing a low byte with the
// wrong high byte.
//
// Parameters:
//   BAUD_DIV  clocks per bit period (minimum 4)
//   PKT_TO    max clocks from the high-byte stop sample to the low-byte
//             start edge before the high byte is dropped (< 16384)
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   RX_A       in   serial line, idle high, asynchronous to clk
//   accel_val  out  [15:0] last complete sample {high,low}
//   vld        out  one-cycle pulse when accel_val updates
//   frm_err    out  one-cycle pulse on stop-bit error or packet timeout
//
// Optional build macro ACCEL_SLV_PKT_CNT_EN adds:
//   pkt_cnt    out  [7:0] wrapping count of vld pulses
//   err_cnt    out  [7:0] saturating count of frm_err pulses
// ---------------------------------------------------------------------------
module accel_slv #(
  parameter int BAUD_DIV = 2604,
  parameter int PKT_TO   = 8192
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX_A,
  output logic [15:0] accel_val,
  output logic        vld,
  output logic        frm_err
`ifdef ACCEL_SLV_PKT_CNT_EN
  ,
  output logic [7:0]  pkt_cnt,
  output logic [7:0]  err_cnt
`endif
);

  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BW-1:0] HALF_LAST = BW'(BAUD_DIV / 2 - 1);
  localparam logic [BW-1:0] FULL_LAST = BW'(BAUD_DIV - 1);
  localparam logic [13:0]   TO_LAST   = 14'(PKT_TO - 1);
  localparam logic [13:0]   TO_MAX    = 14'h3FFF;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [0:0] P_WAIT_HIGH = 1'b0;
  localparam logic [0:0] P_WAIT_LOW  = 1'b1;

  logic          r_rxMeta;
  logic          r_rxS;
  logic          r_rxPrev;
  logic [1:0]    r_bitState;
  logic [BW-1:0] r_baudCnt;
  logic [3:0]    r_bitCnt;
  logic [7:0]    r_shift;
  logic [0:0]    r_pktState;
  logic [7:0]    r_hiQ;
  logic [13:0]   r_toCnt;
  logic [15:0]   r_accelVal;
  logic          r_vld;
  logic          r_frmErr;

  logic w_startEdge;
  logic w_stopSample;
  logic w_byteRdy;
  logic w_byteErr;
  logic w_bitIdle;
  logic w_timeout;
  logic w_setVld;
  logic w_setErr;

  // Two-flop synchroniser plus a history flop for falling-edge detection.
  // Resetting to 1 means the first falling edge after reset is a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rxMeta <= 1'b1;
      r_rxS    <= 1'b1;
      r_rxPrev <= 1'b1;
    end else begin
      r_rxMeta <= RX_A;
      r_rxS    <= r_rxMeta;
      r_rxPrev <= r_rxS;
    end
  end

  assign w_startEdge  = r_rxPrev & ~r_rxS;
  assign w_stopSample = (r_bitState == S_STOP) && (r_baudCnt == FULL_LAST);
  assign w_byteRdy    = w_stopSample & r_rxS;
  assign w_byteErr    = w_stopSample & ~r_rxS;
  assign w_bitIdle    = (r_bitState == S_IDLE);

  // Bit FSM. The start bit is checked at its middle; after that every
  // sample lands a full bit period later, i.e. at mid-bit. The stop bit is
  // judged at its middle and the FSM returns to IDLE straight away so a
  // back-to-back start edge is not missed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bitState <= S_IDLE;
      r_baudCnt  <= '0;
      r_bitCnt   <= 4'd0;
      r_shift    <= 8'h00;
    end else begin
      case (r_bitState)
        S_IDLE: begin
          if (w_startEdge) begin
            r_baudCnt  <= '0;
            r_bitState <= S_START;
          end
        end
        S_START: begin
          if (r_baudCnt == HALF_LAST) begin
            r_baudCnt <= '0;
            if (r_rxS) begin
              r_bitState <= S_IDLE;
            end else begin
              r_bitCnt   <= 4'd0;
              r_bitState <= S_DATA;
            end
          end else begin
            r_baudCnt <= r_baudCnt + 1'b1;
          end
        end
        S_DATA: begin
          if (r_baudCnt == FULL_LAST) begin
            r_baudCnt <= '0;
            r_shift   <= {r_rxS, r_shift[7:1]};
            r_bitCnt  <= r_bitCnt + 4'd1;
            if (r_bitCnt == 4'd7) begin
              r_bitState <= S_STOP;
            end
          end else begin
            r_baudCnt <= r_baudCnt + 1'b1;
          end
        end
        default: begin
          if (r_baudCnt == FULL_LAST) begin
            r_baudCnt  <= '0;
            r_bitState <= S_IDLE;
          end else begin
            r_baudCnt <= r_baudCnt + 1'b1;
          end
        end
      endcase
    end
  end

  // The timeout only runs while the line is quiet: a start edge in the same
  // cycle as the last count beats the timeout.
  assign w_timeout = (r_pktState == P_WAIT_LOW) && w_bitIdle && !w_startEdge &&
                     (r_toCnt == TO_LAST);
  assign w_setVld  = (r_pktState == P_WAIT_LOW) && w_byteRdy;
  assign w_setErr  = w_byteErr | w_timeout;

  // Packet FSM: pairs a high byte with the following low byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pktState <= P_WAIT_HIGH;
      r_hiQ      <= 8'h00;
      r_toCnt    <= 14'd0;
      r_accelVal <= 16'h0000;
      r_vld      <= 1'b0;
      r_frmErr   <= 1'b0;
    end else begin
      r_vld    <= w_setVld;
      r_frmErr <= w_setErr;
      if (r_pktState == P_WAIT_HIGH) begin
        if (w_byteRdy) begin
          r_hiQ      <= r_shift;
          r_toCnt    <= 14'd0;
          r_pktState <= P_WAIT_LOW;
        end
      end else begin
        if (w_byteRdy) begin
          r_accelVal <= {r_hiQ, r_shift};
          r_pktState <= P_WAIT_HIGH;
        end else if (w_byteErr || w_timeout) begin
          r_hiQ      <= 8'h00;
          r_pktState <= P_WAIT_HIGH;
        end else if (w_bitIdle && !w_startEdge && (r_toCnt != TO_MAX)) begin
          r_toCnt <= r_toCnt + 14'd1;
        end
      end
    end
  end

  assign accel_val = r_accelVal;
  assign vld       = r_vld;
  assign frm_err   = r_frmErr;

`ifdef ACCEL_SLV_PKT_CNT_EN
  logic [7:0] r_pktCnt;
  logic [7:0] r_errCnt;

  // Packet counter wraps; error counter sticks at its maximum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pktCnt <= 8'h00;
      r_errCnt <= 8'h00;
    end else begin
      if (w_setVld) begin
        r_pktCnt <= r_pktCnt + 8'd1;
      end
      if (w_setErr && (r_errCnt != 8'hFF)) begin
        r_errCnt <= r_errCnt + 8'd1;
      end
    end
  end

  assign pkt_cnt = r_pktCnt;
  assign err_cnt = r_errCnt;
`endif

endmodule
